apb_master_fsm: RTL

APB master sequencer of the AXI4-Lite to APB bridge. It accepts one captured AXI4-Lite read or write request at a time and presents the request address to the address decoder. It takes back the one-hot slave select and runs the APB SETUP/ACCESS protocol on the selected slave. It returns read data and a 2-bit AXI response to the AXI-side response stage.

---
 rtl/apb_master_fsm.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_master_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_fsm
//  Brief    : APB master sequencer of the AXI4-Lite to APB bridge. Takes one
//             captured request, presents its address to the decoder, runs the
//             APB SETUP/ACCESS handshake on the selected slave and returns
//             read data plus a 2-bit AXI response.
//  Options  : APB_TIMEOUT_EN - when defined, an ACCESS phase that sees no
//             PREADY for c_timeout_cycles cycles is terminated with SLVERR.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master_fsm #(
    parameter int c_apb_num_slaves = 1,
    parameter int c_timeout_cycles = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    // request side
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    input  logic [3:0]                    req_strb,
    input  logic [2:0]                    req_prot,
    input  logic                          req_write,
    // address decoder
    output logic [31:0]                   dec_addr,
    input  logic [c_apb_num_slaves-1:0]   slave_sel,
    // APB
    output logic [31:0]                   PADDR,
    output logic [31:0]                   PWDATA,
    output logic [3:0]                    PSTRB,
    output logic [2:0]                    PPROT,
    output logic                          PWRITE,
    output logic                          PENABLE,
    output logic [c_apb_num_slaves-1:0]   PSEL,
    input  logic [32*c_apb_num_slaves-1:0] PRDATA,
    input  logic [c_apb_num_slaves-1:0]   PREADY,
    input  logic [c_apb_num_slaves-1:0]   PSLVERR,
    // response side
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_rdata,
    output logic [1:0]                    rsp_resp
);

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Reject meaningless parameterisations at elaboration time.
    if (c_apb_num_slaves < 1 || c_timeout_cycles < 1) begin : g_param_check
        $error("apb_master_fsm: c_apb_num_slaves and c_timeout_cycles must be >= 1");
    end

    state_t                        r_state;
    state_t                        w_state_nxt;

    // Request captured in IDLE; feeds the decoder and later the APB registers.
    logic [31:0]                   r_addr;
    logic [31:0]                   r_wdata;
    logic [3:0]                    r_strb;
    logic [2:0]                    r_prot;
    logic                          r_write;

    // APB-facing registers, loaded only when a transfer is launched so they
    // hold their previous value while the next request is being decoded.
    logic [c_apb_num_slaves-1:0]   r_sel;
    logic [31:0]                   r_paddr;
    logic [31:0]                   r_pwdata;
    logic [3:0]                    r_pstrb;
    logic [2:0]                    r_pprot;
    logic                          r_pwrite;

    logic [31:0]                   r_rdata;
    logic [1:0]                    r_resp;
    logic [31:0]                   w_rdata_nxt;
    logic [1:0]                    w_resp_nxt;

    logic [c_apb_num_slaves-1:0]   w_sel_low;
    logic                          w_sel_found;
    logic [31:0]                   w_prdata;
    logic                          w_pready;
    logic                          w_pslverr;
    logic                          w_tmo_expired;

    // Keep only the lowest-indexed select bit if the decoder flags several.
    always_comb begin
        w_sel_low   = '0;
        w_sel_found = 1'b0;
        for (int i = 0; i < c_apb_num_slaves; i++) begin
            if (slave_sel[i] && !w_sel_found) begin
                w_sel_low[i] = 1'b1;
                w_sel_found  = 1'b1;
            end
        end
    end

    // Return-path mux: only the selected slave's PRDATA/PREADY/PSLVERR count.
    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < c_apb_num_slaves; i++) begin
            if (r_sel[i]) begin
                w_prdata = w_prdata | PRDATA[32*i +: 32];
            end
        end
    end

    assign w_pready  = |(PREADY & r_sel);
    assign w_pslverr = |(PSLVERR & r_sel);

`ifdef APB_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(c_timeout_cycles + 1);
    logic [c_tmo_w-1:0] r_tmo_cnt;

    // Count ACCESS cycles without PREADY; zero whenever not in ACCESS.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || r_state != S_ACCESS) begin
            r_tmo_cnt <= '0;
        end else if (!w_pready) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end
    end

    // Expiry fires on the c_timeout_cycles-th ACCESS cycle without PREADY.
    assign w_tmo_expired = (r_tmo_cnt == c_tmo_w'(c_timeout_cycles - 1));
`else
    assign w_tmo_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the response value to be latched on entry to RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_rdata_nxt = r_rdata;
        w_resp_nxt  = r_resp;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (slave_sel == '0) begin
                    w_state_nxt = S_RESP;
                    w_rdata_nxt = '0;
                    w_resp_nxt  = c_resp_decerr;
                end else begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_pready) begin
                    w_state_nxt = S_RESP;
                    w_rdata_nxt = r_pwrite ? 32'h0 : w_prdata;
                    w_resp_nxt  = w_pslverr ? c_resp_slverr : c_resp_okay;
                end else if (w_tmo_expired) begin
                    w_state_nxt = S_RESP;
                    w_rdata_nxt = '0;
                    w_resp_nxt  = c_resp_slverr;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request on the IDLE handshake.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
            r_write <= 1'b0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_strb  <= req_strb;
            r_prot  <= req_prot;
            r_write <= req_write;
        end
    end

    // Latch the slave select and APB payload when leaving DECODE.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_sel    <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
            r_pwrite <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_sel <= w_sel_low;
            if (slave_sel != '0) begin
                r_paddr  <= r_addr;
                r_pwdata <= r_wdata;
                r_pstrb  <= r_write ? r_strb : 4'h0;
                r_pprot  <= r_prot;
                r_pwrite <= r_write;
            end
        end
    end

    // Response registers; held stable through RESP until the handshake.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rdata <= '0;
            r_resp  <= c_resp_okay;
        end else begin
            r_rdata <= w_rdata_nxt;
            r_resp  <= w_resp_nxt;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;
    assign dec_addr  = r_addr;

    assign PSEL      = (r_state == S_SETUP || r_state == S_ACCESS) ? r_sel : '0;
    assign PENABLE   = (r_state == S_ACCESS);
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = r_pprot;
    assign PWRITE    = r_pwrite;

endmodule
`default_nettype wire
